note_recorder: RTL and testbench

NOTE_RECORDER -- requirements
Module: note_recorder

---
 rtl/note_recorder_pkg.sv | 22 ++
 rtl/note_recorder_note_buffer.sv | 23 ++
 rtl/note_recorder.sv | 156 +++++++++++++++
 tb/tb_note_recorder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_recorder_pkg.sv
// Shared note codes and FSM state encodings for the note recorder slice.
package note_recorder_pkg;

  localparam int NOTE_W = 4;

  localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_D    = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_E    = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_F    = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_G    = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_A    = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_B    = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

endpackage

// File: rtl/note_recorder_note_buffer.sv
// Single-port note storage with a registered read; contents are not reset.
module note_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 12,
  parameter int AW    = 6
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/note_recorder.sv
// Records {note, duration} runs on TICK pulses and replays them in order.
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int DUR_W = 8
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     TICK,
  input  logic                     REC,
  input  logic                     PLAY,
  input  logic [NOTE_W-1:0]        note_in,
  output logic [NOTE_W-1:0]        note_out,
  output logic                     recording,
  output logic                     playing,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = NOTE_W + DUR_W;
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

  state_t            state, state_n;
  logic [NOTE_W-1:0] cur_note, cur_note_n;
  logic [DUR_W-1:0]  dur, dur_n;
  logic [DUR_W-1:0]  remain, remain_n;
  logic [CW-1:0]     rd_ptr, rd_ptr_n;
  logic [CW-1:0]     count_n;
  logic              full_n;
  logic [NOTE_W-1:0] note_out_n;
  logic              first, first_n;
  logic              we;
  logic [EW-1:0]     wdata;
  logic [EW-1:0]     rdata;
  logic [AW-1:0]     addr;

  // rd_ptr_n drives the RAM address so the next entry is already in rdata
  // by the time the current one finishes, even with TICK on every cycle.
  assign addr  = we ? count[AW-1:0] : rd_ptr_n[AW-1:0];
  assign wdata = {cur_note, dur};

  note_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_buf (
    .CLK   (CLK),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_comb begin
    state_n    = state;
    cur_note_n = cur_note;
    dur_n      = dur;
    remain_n   = remain;
    rd_ptr_n   = rd_ptr;
    count_n    = count;
    full_n     = full;
    note_out_n = NOTE_NONE;
    first_n    = 1'b0;
    we         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (REC) begin
          count_n    = '0;
          full_n     = 1'b0;
          cur_note_n = note_in;
          dur_n      = '0;
          state_n    = ST_RECORD;
        end else if (PLAY && (count != '0)) begin
          rd_ptr_n = '0;
          first_n  = 1'b1;
          state_n  = ST_PLAY;
        end
      end
      ST_RECORD: begin
        if (REC) begin
          we      = (dur != '0);
          state_n = ST_IDLE;
        end else if (TICK) begin
          if (note_in != cur_note) begin
            we         = (dur != '0);
            cur_note_n = note_in;
            dur_n      = DUR_W'(1);
          end else if (dur == DUR_MAX) begin
            we    = 1'b1;
            dur_n = DUR_W'(1);
          end else begin
            dur_n = dur + 1'b1;
          end
        end
        if (we) begin
          count_n = count + 1'b1;
          if (count_n == CW'(DEPTH)) begin
            full_n  = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      ST_PLAY: begin
        note_out_n = note_out;
        if (PLAY) begin
          note_out_n = NOTE_NONE;
          state_n    = ST_IDLE;
        end else if (first || (TICK && (remain == DUR_W'(1)) && (rd_ptr != count))) begin
          note_out_n = rdata[EW-1:DUR_W];
          remain_n   = rdata[DUR_W-1:0];
          rd_ptr_n   = rd_ptr + 1'b1;
        end else if (TICK) begin
          if (remain > DUR_W'(1)) begin
            remain_n = remain - 1'b1;
          end else begin
            note_out_n = NOTE_NONE;
            state_n    = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      cur_note  <= NOTE_NONE;
      dur       <= '0;
      remain    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      note_out  <= NOTE_NONE;
      first     <= 1'b0;
      recording <= 1'b0;
      playing   <= 1'b0;
    end else begin
      state     <= state_n;
      cur_note  <= cur_note_n;
      dur       <= dur_n;
      remain    <= remain_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      full      <= full_n;
      note_out  <= note_out_n;
      first     <= first_n;
      recording <= (state_n == ST_RECORD);
      playing   <= (state_n == ST_PLAY);
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Directed self-checking bench for note_recorder (DEPTH=4, DUR_W=8).
module tb_note_recorder;
  import note_recorder_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       TICK = 1'b0;
  logic       REC = 1'b0;
  logic       PLAY = 1'b0;
  logic [3:0] note_in = NOTE_NONE;
  logic [3:0] note_out;
  logic       recording;
  logic       playing;
  logic       full;
  logic [2:0] count;

  int checks = 0;
  int failures = 0;

  note_recorder #(.DEPTH(4), .DUR_W(8)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .TICK      (TICK),
    .REC       (REC),
    .PLAY      (PLAY),
    .note_in   (note_in),
    .note_out  (note_out),
    .recording (recording),
    .playing   (playing),
    .full      (full),
    .count     (count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (got timeout, want completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs at a falling edge; outputs are sampled at the next one.
  task automatic drive(input logic t, input logic r, input logic p, input logic [3:0] n);
    TICK = t; REC = r; PLAY = p; note_in = n;
    @(negedge CLK);
    TICK = 1'b0; REC = 1'b0; PLAY = 1'b0;
  endtask

  task automatic test_reset;
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    checks++;
    if ({note_out, recording, playing, full, count} !== {NOTE_NONE, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL reset_state: got note_out=%0d rec=%0b play=%0b full=%0b count=%0d want 0/0/0/0/0",
               note_out, recording, playing, full, count);
    end
  endtask

  task automatic test_empty_play;
    drive(1'b0, 1'b0, 1'b1, NOTE_NONE);
    drive(1'b0, 1'b0, 1'b0, NOTE_NONE);
    checks++;
    if (playing !== 1'b0 || note_out !== NOTE_NONE) begin
      failures++;
      $display("FAIL empty_play: got playing=%0b note_out=%0d want 0/0", playing, note_out);
    end
  endtask

  task automatic test_record_play;
    logic [3:0] exp_seq [5];
    exp_seq[0] = NOTE_C4; exp_seq[1] = NOTE_C4; exp_seq[2] = NOTE_C4;
    exp_seq[3] = NOTE_E;  exp_seq[4] = NOTE_E;
    drive(1'b0, 1'b1, 1'b0, NOTE_C4);
    checks++;
    if (recording !== 1'b1) begin
      failures++;
      $display("FAIL rec_start: got recording=%0b want 1", recording);
    end
    repeat (3) drive(1'b1, 1'b0, 1'b0, NOTE_C4);
    drive(1'b1, 1'b0, 1'b0, NOTE_E);
    drive(1'b0, 1'b0, 1'b0, NOTE_E);
    drive(1'b1, 1'b0, 1'b0, NOTE_E);
    drive(1'b0, 1'b1, 1'b0, NOTE_E);
    checks++;
    if (recording !== 1'b0 || count !== 3'd2) begin
      failures++;
      $display("FAIL rec_stop: got recording=%0b count=%0d want 0/2", recording, count);
    end
    checks++;
    if (dut.u_buf.mem[0] !== {NOTE_C4, 8'd3} || dut.u_buf.mem[1] !== {NOTE_E, 8'd2}) begin
      failures++;
      $display("FAIL rec_entries: got %h %h want %h %h", dut.u_buf.mem[0], dut.u_buf.mem[1],
               {NOTE_C4, 8'd3}, {NOTE_E, 8'd2});
    end
    drive(1'b0, 1'b0, 1'b1, NOTE_NONE);
    checks++;
    if (playing !== 1'b1) begin
      failures++;
      $display("FAIL play_start: got playing=%0b want 1", playing);
    end
    drive(1'b0, 1'b0, 1'b0, NOTE_NONE);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (note_out !== exp_seq[i]) begin
        failures++;
        $display("FAIL play_note[%0d]: got %0d want %0d", i, note_out, exp_seq[i]);
      end
      drive(1'b1, 1'b0, 1'b0, NOTE_NONE);
    end
    checks++;
    if (note_out !== NOTE_NONE || playing !== 1'b0) begin
      failures++;
      $display("FAIL play_end: got note_out=%0d playing=%0b want 0/0", note_out, playing);
    end
  endtask

  task automatic test_abort;
    drive(1'b0, 1'b0, 1'b1, NOTE_NONE);
    drive(1'b0, 1'b0, 1'b0, NOTE_NONE);
    checks++;
    if (note_out !== NOTE_C4 || playing !== 1'b1) begin
      failures++;
      $display("FAIL replay_start: got note_out=%0d playing=%0b want %0d/1", note_out, playing, NOTE_C4);
    end
    drive(1'b1, 1'b0, 1'b0, NOTE_NONE);
    drive(1'b0, 1'b1, 1'b0, NOTE_NONE);
    checks++;
    if (recording !== 1'b0 || note_out !== NOTE_C4) begin
      failures++;
      $display("FAIL rec_in_play: got recording=%0b note_out=%0d want 0/%0d", recording, note_out, NOTE_C4);
    end
    drive(1'b0, 1'b0, 1'b1, NOTE_NONE);
    checks++;
    if (note_out !== NOTE_NONE || playing !== 1'b0 || recording !== 1'b0) begin
      failures++;
      $display("FAIL abort: got note_out=%0d playing=%0b recording=%0b want 0/0/0",
               note_out, playing, recording);
    end
  endtask

  task automatic test_saturation;
    drive(1'b0, 1'b1, 1'b0, NOTE_G);
    repeat (300) drive(1'b1, 1'b0, 1'b0, NOTE_G);
    checks++;
    if (recording !== 1'b1 || count !== 3'd1) begin
      failures++;
      $display("FAIL sat_running: got recording=%0b count=%0d want 1/1", recording, count);
    end
    drive(1'b0, 1'b1, 1'b0, NOTE_G);
    checks++;
    if (count !== 3'd2 || dut.u_buf.mem[0] !== {NOTE_G, 8'd255} || dut.u_buf.mem[1] !== {NOTE_G, 8'd45}) begin
      failures++;
      $display("FAIL saturation: got count=%0d %h %h want 2 %h %h", count, dut.u_buf.mem[0],
               dut.u_buf.mem[1], {NOTE_G, 8'd255}, {NOTE_G, 8'd45});
    end
  endtask

  task automatic test_coincidence;
    drive(1'b0, 1'b1, 1'b0, NOTE_C4);
    repeat (2) drive(1'b1, 1'b0, 1'b0, NOTE_C4);
    drive(1'b1, 1'b1, 1'b0, NOTE_C4);
    checks++;
    if (count !== 3'd1 || recording !== 1'b0 || dut.u_buf.mem[0] !== {NOTE_C4, 8'd2}) begin
      failures++;
      $display("FAIL rec_tick_coincide: got count=%0d recording=%0b entry=%h want 1/0/%h",
               count, recording, dut.u_buf.mem[0], {NOTE_C4, 8'd2});
    end
    drive(1'b0, 1'b1, 1'b1, NOTE_D);
    checks++;
    if (recording !== 1'b1 || playing !== 1'b0) begin
      failures++;
      $display("FAIL rec_play_coincide: got recording=%0b playing=%0b want 1/0", recording, playing);
    end
    drive(1'b0, 1'b1, 1'b0, NOTE_D);
    checks++;
    if (count !== 3'd0 || recording !== 1'b0) begin
      failures++;
      $display("FAIL empty_rec: got count=%0d recording=%0b want 0/0", count, recording);
    end
  endtask

  task automatic test_full;
    drive(1'b0, 1'b1, 1'b0, NOTE_C4);
    drive(1'b1, 1'b0, 1'b0, NOTE_C4);
    drive(1'b0, 1'b0, 1'b1, NOTE_C4);
    checks++;
    if (recording !== 1'b1 || playing !== 1'b0) begin
      failures++;
      $display("FAIL play_in_rec: got recording=%0b playing=%0b want 1/0", recording, playing);
    end
    drive(1'b1, 1'b0, 1'b0, NOTE_D);
    drive(1'b1, 1'b0, 1'b0, NOTE_E);
    drive(1'b1, 1'b0, 1'b0, NOTE_F);
    checks++;
    if (count !== 3'd3 || full !== 1'b0 || recording !== 1'b1) begin
      failures++;
      $display("FAIL before_full: got count=%0d full=%0b recording=%0b want 3/0/1", count, full, recording);
    end
    drive(1'b1, 1'b0, 1'b0, NOTE_G);
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || recording !== 1'b0 || dut.u_buf.mem[3] !== {NOTE_F, 8'd1}) begin
      failures++;
      $display("FAIL full: got count=%0d full=%0b recording=%0b entry=%h want 4/1/0/%h",
               count, full, recording, dut.u_buf.mem[3], {NOTE_F, 8'd1});
    end
    repeat (2) drive(1'b1, 1'b0, 1'b0, NOTE_A);
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || recording !== 1'b0) begin
      failures++;
      $display("FAIL full_discard: got count=%0d full=%0b recording=%0b want 4/1/0", count, full, recording);
    end
  endtask

  task automatic test_reset_mid_play;
    drive(1'b0, 1'b0, 1'b1, NOTE_NONE);
    drive(1'b0, 1'b0, 1'b0, NOTE_NONE);
    checks++;
    if (playing !== 1'b1 || note_out !== NOTE_C4) begin
      failures++;
      $display("FAIL full_replay: got playing=%0b note_out=%0d want 1/%0d", playing, note_out, NOTE_C4);
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({note_out, recording, playing, full, count} !== {NOTE_NONE, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL async_reset: got note_out=%0d rec=%0b play=%0b full=%0b count=%0d want 0/0/0/0/0",
               note_out, recording, playing, full, count);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    drive(1'b0, 1'b0, 1'b1, NOTE_NONE);
    checks++;
    if (playing !== 1'b0) begin
      failures++;
      $display("FAIL play_after_reset: got playing=%0b want 0", playing);
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_empty_play();
    test_record_play();
    test_abort();
    test_saturation();
    test_coincidence();
    test_full();
    test_reset_mid_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
